// File: rtl/frv_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// frv_dmem_arbiter
//
// Shares the single core data-memory port between two requesters:
//   r0 : memory-stage LSU
//   r1 : coprocessor / DMA master
// The request channel is arbitrated combinationally, so a request that wins
// and is granted by memory completes in the same cycle it is presented. This
// adds no request latency. Responses come back from memory in issue order. A
// small FIFO of requester IDs records who issued each accepted transaction, and
// each response is routed back to that requester.
//
// Handshake semantics (both channels):
//   request  : a transfer happens on a cycle where req && gnt. A requester
//              that raised req keeps req and its fields stable until it sees
//              gnt.
//   response : a transfer happens on a cycle where recv && ack. Memory keeps
//              recv/rdata/error stable until it sees ack.
//
// Parameters
//   OUTSTANDING : max accepted-but-unanswered transactions (1..4)
//   FIXED_PRIO  : 0 = round-robin on conflict, 1 = r0 always wins a conflict
//
// Optional feature
//   FRV_DMEM_ARB_PERF_EN : when defined, perf_conflicts counts the cycles in
//                          which both requesters raise req. The counter
//                          saturates at all-ones. When undefined, the output is
//                          tied to zero and the design contains no counter flops.
//
// Ports
//   g_clk, g_reset              clock, asynchronous active-high reset
//   r{0,1}_req/wen/strb/addr/wdata   requester request channel (in)
//   r{0,1}_gnt                  request accepted downstream this cycle
//   r{0,1}_recv/rdata/error     response channel to requester
//   r{0,1}_ack                  requester accepts response
//   dmem_req/wen/strb/addr/wdata     muxed request to memory
//   dmem_gnt                    memory accepts request
//   dmem_recv/rdata/error       memory response
//   dmem_ack                    response accepted
//   perf_conflicts              contention-cycle counter
//   dbg_state                   arbiter FSM state (0 IDLE, 1 HOLD0, 2 HOLD1)
// -----------------------------------------------------------------------------
module frv_dmem_arbiter #(
  parameter int OUTSTANDING = 2,
  parameter int FIXED_PRIO  = 0
) (
  input  logic        g_clk,
  input  logic        g_reset,

  input  logic        r0_req,
  input  logic        r0_wen,
  input  logic [3:0]  r0_strb,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_gnt,
  output logic        r0_recv,
  input  logic        r0_ack,
  output logic [31:0] r0_rdata,
  output logic        r0_error,

  input  logic        r1_req,
  input  logic        r1_wen,
  input  logic [3:0]  r1_strb,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_gnt,
  output logic        r1_recv,
  input  logic        r1_ack,
  output logic [31:0] r1_rdata,
  output logic        r1_error,

  output logic        dmem_req,
  output logic        dmem_wen,
  output logic [3:0]  dmem_strb,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_recv,
  output logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_error,

  output logic [31:0] perf_conflicts,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTANDING - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD0 = 2'd1,
    ST_HOLD1 = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   last_q;     // requester granted most recently
  logic [OUTSTANDING-1:0] id_mem_q;   // issuing requester per FIFO slot
  logic [PW-1:0]          wr_ptr_q;
  logic [PW-1:0]          rd_ptr_q;
  logic [CW-1:0]          count_q;

  logic sel;       // requester currently driving the memory request
  logic sel_req;
  logic full;
  logic empty;
  logic accept;    // request transfer this cycle
  logic pop;       // response transfer for a tracked transaction
  logic head_id;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Occupancy is registered. A response popped this cycle does not free a
  // slot for a request until the next cycle.
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // ---------------------------------------------------------------------------
  // Request arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    sel = 1'b0;
    case (state_q)
      ST_HOLD0: sel = 1'b0;
      ST_HOLD1: sel = 1'b1;
      default: begin
        if (r0_req && r1_req) begin
          // Round-robin picks the requester that did not win last.
          sel = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
        end else begin
          sel = r1_req;
        end
      end
    endcase
  end

  assign sel_req = sel ? r1_req : r0_req;

  // Gating with g_reset keeps the request low while reset is held, even if a
  // requester still drives req.
  assign dmem_req   = sel_req && !full && !g_reset;
  assign dmem_wen   = sel ? r1_wen   : r0_wen;
  assign dmem_strb  = sel ? r1_strb  : r0_strb;
  assign dmem_addr  = sel ? r1_addr  : r0_addr;
  assign dmem_wdata = sel ? r1_wdata : r0_wdata;

  assign accept = dmem_req && dmem_gnt;
  assign r0_gnt = accept && !sel;
  assign r1_gnt = accept &&  sel;

  // ---------------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------------
  assign head_id = id_mem_q[rd_ptr_q];

  assign r0_recv  = dmem_recv && !empty && !head_id;
  assign r1_recv  = dmem_recv && !empty &&  head_id;
  assign r0_rdata = dmem_rdata;
  assign r1_rdata = dmem_rdata;
  assign r0_error = dmem_error;
  assign r1_error = dmem_error;

  // With nothing outstanding, a stray response is drained so that memory
  // cannot stall on it.
  assign dmem_ack = empty ? 1'b1 : (head_id ? r1_ack : r0_ack);
  assign pop      = dmem_recv && dmem_ack && !empty;

  // ---------------------------------------------------------------------------
  // Arbiter FSM. HOLDx locks the mux to x after memory stalls a request, so
  // the presented fields cannot change under the memory. HOLDx is entered only
  // from a non-full IDLE. Only a grant pushes, so the lock always completes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dmem_req) begin
            if (dmem_gnt) begin
              last_q <= sel;
            end else begin
              state_q <= sel ? ST_HOLD1 : ST_HOLD0;
            end
          end
        end
        ST_HOLD0, ST_HOLD1: begin
          if (accept) begin
            last_q  <= sel;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Outstanding-ID FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      id_mem_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) begin
        id_mem_q[wr_ptr_q] <= sel;
        wr_ptr_q           <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Contention counter. Only one request can be granted per cycle, so every
  // cycle with both requesters active is a contention cycle.
  // ---------------------------------------------------------------------------
`ifdef FRV_DMEM_ARB_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      perf_q <= 32'd0;
    end else if (r0_req && r1_req && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_conflicts = perf_q;
`else
  assign perf_conflicts = 32'd0;
`endif

endmodule

// File: tb/tb_frv_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_frv_dmem_arbiter
//
// The reference model tracks the following items with queues:
//   - the issuing requester of every accepted transaction
//   - the responses a simulated memory owes
//   - the responses each requester expects
// The model computes the expected outputs from the arbitration rules and checks
// them every cycle. Directed sequences pin the model with literal
// expectations. Randomized phases then stress the arbiter.
// -----------------------------------------------------------------------------
module tb_frv_dmem_arbiter;

  localparam int OUTSTANDING = 2;
  localparam int FIXED_PRIO  = 0;

  logic        g_clk;
  logic        g_reset;
  logic        r0_req, r0_wen, r0_gnt, r0_recv, r0_ack, r0_error;
  logic [3:0]  r0_strb;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic        r1_req, r1_wen, r1_gnt, r1_recv, r1_ack, r1_error;
  logic [3:0]  r1_strb;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic        dmem_req, dmem_wen, dmem_gnt, dmem_recv, dmem_ack, dmem_error;
  logic [3:0]  dmem_strb;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] perf_conflicts;
  logic [1:0]  dbg_state;

  frv_dmem_arbiter #(
    .OUTSTANDING (OUTSTANDING),
    .FIXED_PRIO  (FIXED_PRIO)
  ) dut (
    .g_clk          (g_clk),
    .g_reset        (g_reset),
    .r0_req         (r0_req),
    .r0_wen         (r0_wen),
    .r0_strb        (r0_strb),
    .r0_addr        (r0_addr),
    .r0_wdata       (r0_wdata),
    .r0_gnt         (r0_gnt),
    .r0_recv        (r0_recv),
    .r0_ack         (r0_ack),
    .r0_rdata       (r0_rdata),
    .r0_error       (r0_error),
    .r1_req         (r1_req),
    .r1_wen         (r1_wen),
    .r1_strb        (r1_strb),
    .r1_addr        (r1_addr),
    .r1_wdata       (r1_wdata),
    .r1_gnt         (r1_gnt),
    .r1_recv        (r1_recv),
    .r1_ack         (r1_ack),
    .r1_rdata       (r1_rdata),
    .r1_error       (r1_error),
    .dmem_req       (dmem_req),
    .dmem_wen       (dmem_wen),
    .dmem_strb      (dmem_strb),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_gnt       (dmem_gnt),
    .dmem_recv      (dmem_recv),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .dmem_error     (dmem_error),
    .perf_conflicts (perf_conflicts),
    .dbg_state      (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // ---------------------------------------------------------------------------
  // Counters and compare helper
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model state
  // ---------------------------------------------------------------------------
  int          last_w;          // requester granted most recently
  int          lock;            // -1 none, else requester holding the port
  int          id_q[$];         // issuers of outstanding transactions
  logic [32:0] mem_q[$];        // {error,data} owed by memory, in order
  logic [32:0] exp_q0[$];       // responses r0 expects
  logic [32:0] exp_q1[$];       // responses r1 expects
  bit          resp_active;
  logic [32:0] cur_resp;
  int          exp_perf;

  bit          pend   [2];
  logic [31:0] f_addr [2];
  logic [31:0] f_wdata[2];
  logic [3:0]  f_strb [2];
  logic        f_wen  [2];

  int req_pct, gnt_pct, recv_pct, ack_pct;

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  task automatic reset_model();
    last_w = 1;
    lock   = -1;
    id_q.delete();
    mem_q.delete();
    exp_q0.delete();
    exp_q1.delete();
    resp_active = 1'b0;
    cur_resp    = '0;
    exp_perf    = 0;
    pend[0]     = 1'b0;
    pend[1]     = 1'b0;
  endtask

  task automatic zero_inputs();
    r0_req = 0; r0_wen = 0; r0_strb = '0; r0_addr = '0; r0_wdata = '0; r0_ack = 0;
    r1_req = 0; r1_wen = 0; r1_strb = '0; r1_addr = '0; r1_wdata = '0; r1_ack = 0;
    dmem_gnt = 0; dmem_recv = 0; dmem_rdata = '0; dmem_error = 0;
  endtask

  // Asserts reset and checks the outputs right away, without waiting for a
  // clock edge. Then holds reset for two edges and releases it 1 time unit
  // after a posedge.
  task automatic do_reset();
    g_reset = 1'b1;
    #1;
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_r0_gnt",   r0_gnt,   0);
    chk("rst_r1_gnt",   r1_gnt,   0);
    chk("rst_r0_recv",  r0_recv,  0);
    chk("rst_r1_recv",  r1_recv,  0);
    chk("rst_dmem_ack", dmem_ack, 1);
    chk("rst_perf",     perf_conflicts, 0);
    chk("rst_state",    dbg_state, 0);
    zero_inputs();
    repeat (2) @(posedge g_clk);
    #1;
    g_reset = 1'b0;
    reset_model();
  endtask

  // ---------------------------------------------------------------------------
  // Driver. Call 1 time unit after a posedge.
  // ---------------------------------------------------------------------------
  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && pct(req_pct)) begin
        pend[i]    = 1'b1;
        f_addr[i]  = $urandom;
        f_wdata[i] = $urandom;
        f_strb[i]  = 4'($urandom_range(0, 15));
        f_wen[i]   = 1'($urandom_range(0, 1));
      end
    end
    if (!resp_active && mem_q.size() > 0 && pct(recv_pct)) begin
      resp_active = 1'b1;
      cur_resp    = mem_q.pop_front();
    end
    r0_req = pend[0]; r0_wen = f_wen[0]; r0_strb = f_strb[0];
    r0_addr = f_addr[0]; r0_wdata = f_wdata[0];
    r1_req = pend[1]; r1_wen = f_wen[1]; r1_strb = f_strb[1];
    r1_addr = f_addr[1]; r1_wdata = f_wdata[1];
    dmem_gnt   = pct(gnt_pct);
    dmem_recv  = resp_active;
    dmem_rdata = cur_resp[31:0];
    dmem_error = cur_resp[32];
    r0_ack     = pct(ack_pct);
    r1_ack     = pct(ack_pct);
  endtask

  // ---------------------------------------------------------------------------
  // Model cycle. Checks at the negedge, then advances the model by what
  // happens at the next posedge. Returns 1 time unit after that posedge.
  // ---------------------------------------------------------------------------
  task automatic model_cycle();
    int          w;
    bit          wreq, e_req, e_empty, e_ack, e_recv0, e_recv1;
    int          head;
    logic [32:0] rsp;
    @(negedge g_clk);
    if (lock >= 0)               w = lock;
    else if (r0_req && !r1_req)  w = 0;
    else if (r1_req && !r0_req)  w = 1;
    else if (r0_req && r1_req)   w = (FIXED_PRIO != 0) ? 0 : 1 - last_w;
    else                         w = 0;
    wreq    = (w == 0) ? r0_req : r1_req;
    e_req   = wreq && (id_q.size() < OUTSTANDING);
    e_empty = (id_q.size() == 0);
    head    = e_empty ? 0 : id_q[0];
    e_recv0 = dmem_recv && !e_empty && head == 0;
    e_recv1 = dmem_recv && !e_empty && head == 1;
    e_ack   = e_empty ? 1'b1 : ((head == 0) ? r0_ack : r1_ack);

    chk("dmem_req", dmem_req, e_req);
    chk("r0_gnt",   r0_gnt,   e_req && dmem_gnt && w == 0);
    chk("r1_gnt",   r1_gnt,   e_req && dmem_gnt && w == 1);
    chk("r0_recv",  r0_recv,  e_recv0);
    chk("r1_recv",  r1_recv,  e_recv1);
    chk("dmem_ack", dmem_ack, e_ack);
    chk("state",    dbg_state, (lock < 0) ? 0 : lock + 1);
`ifdef FRV_DMEM_ARB_PERF_EN
    chk("perf", perf_conflicts, exp_perf);
`else
    chk("perf", perf_conflicts, 0);
`endif
    if (e_req) begin
      chk("dmem_addr",  dmem_addr,  f_addr[w]);
      chk("dmem_wdata", dmem_wdata, f_wdata[w]);
      chk("dmem_ctl",   {dmem_wen, dmem_strb}, {f_wen[w], f_strb[w]});
    end
    if (e_recv0 && r0_ack && exp_q0.size() > 0)
      chk("r0_resp", {r0_error, r0_rdata}, exp_q0.pop_front());
    if (e_recv1 && r1_ack && exp_q1.size() > 0)
      chk("r1_resp", {r1_error, r1_rdata}, exp_q1.pop_front());

    if (r0_req && r1_req) exp_perf++;
    if (e_req && dmem_gnt) begin
      id_q.push_back(w);
      last_w  = w;
      lock    = -1;
      pend[w] = 1'b0;
      rsp[31:0] = $urandom;
      rsp[32]   = ($urandom_range(0, 7) == 0);
      mem_q.push_back(rsp);
      if (w == 0) exp_q0.push_back(rsp);
      else        exp_q1.push_back(rsp);
    end else if (e_req) begin
      lock = w;
    end
    if (dmem_recv && e_ack) begin
      if (!e_empty) void'(id_q.pop_front());
      resp_active = 1'b0;
    end
    @(posedge g_clk);
    #1;
  endtask

  task automatic set_knobs(input int rq, input int gn, input int rc, input int ak);
    req_pct = rq; gnt_pct = gn; recv_pct = rc; ack_pct = ak;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    zero_inputs();
    reset_model();
    set_knobs(0, 0, 0, 0);
    f_addr[0] = '0; f_addr[1] = '0; f_wdata[0] = '0; f_wdata[1] = '0;
    f_strb[0] = '0; f_strb[1] = '0; f_wen[0] = 0; f_wen[1] = 0;
    do_reset();

    // 1: lone r0 request, granted same cycle, response routed to r0
    set_knobs(0, 100, 100, 100);
    pend[0] = 1; f_addr[0] = 32'h1000_0040; f_wdata[0] = 32'hCAFE_0001;
    f_strb[0] = 4'hF; f_wen[0] = 1'b0;
    drive(); #1;
    chk("t1_r0_gnt", r0_gnt, 1);
    chk("t1_r1_gnt", r1_gnt, 0);
    chk("t1_addr",   dmem_addr, 32'h1000_0040);
    model_cycle();
    drive(); #1;
    chk("t1_r0_recv", r0_recv, 1);
    chk("t1_r1_recv", r1_recv, 0);
    chk("t1_rdata",   r0_rdata, cur_resp[31:0]);
    model_cycle();

    // 2: both requesting every cycle, round-robin r0,r1,r0,...
    do_reset();
    set_knobs(100, 100, 100, 100);
    for (int k = 0; k < 10; k++) begin
      drive(); #1;
      chk("t2_r0_gnt", r0_gnt, (k % 2) == 0);
      chk("t2_r1_gnt", r1_gnt, (k % 2) == 1);
      model_cycle();
    end
`ifdef FRV_DMEM_ARB_PERF_EN
    chk("t6_perf", perf_conflicts, 10);
`else
    chk("t6_perf", perf_conflicts, 0);
`endif

    // 3: r1 stalled for 3 cycles holds the port against r0
    do_reset();
    set_knobs(0, 0, 0, 100);
    pend[1] = 1; f_addr[1] = 32'h2000_0100;
    drive(); #1;
    chk("t3_c0_addr",   dmem_addr, 32'h2000_0100);
    chk("t3_c0_r1_gnt", r1_gnt, 0);
    model_cycle();
    pend[0] = 1; f_addr[0] = 32'h3000_0000;
    for (int k = 0; k < 2; k++) begin
      drive(); #1;
      chk("t3_hold_addr",  dmem_addr, 32'h2000_0100);
      chk("t3_hold_r0gnt", r0_gnt, 0);
      chk("t3_hold_state", dbg_state, 2);
      model_cycle();
    end
    gnt_pct = 100;
    drive(); #1;
    chk("t3_r1_gnt", r1_gnt, 1);
    chk("t3_r0_gnt", r0_gnt, 0);
    model_cycle();
    drive(); #1;
    chk("t3_r0_gnt_next", r0_gnt, 1);
    chk("t3_r0_addr",     dmem_addr, 32'h3000_0000);
    model_cycle();

    // 4: full blocks requests; a same-cycle pop does not bypass
    do_reset();
    set_knobs(0, 100, 0, 100);
    for (int k = 0; k < 2; k++) begin
      pend[0] = 1;
      drive();
      model_cycle();
    end
    pend[0] = 1;
    drive(); #1;
    chk("t4_full_req", dmem_req, 0);
    chk("t4_full_gnt", r0_gnt, 0);
    model_cycle();
    recv_pct = 100;
    drive(); #1;
    chk("t4_pop_recv", r0_recv, 1);
    chk("t4_pop_gnt",  r0_gnt, 0);
    model_cycle();
    recv_pct = 0;
    drive(); #1;
    chk("t4_after_gnt", r0_gnt, 1);
    model_cycle();

    // 5: reset while HOLD0 with one transaction outstanding
    do_reset();
    set_knobs(0, 100, 0, 0);
    pend[0] = 1;
    drive();
    model_cycle();
    gnt_pct = 0;
    pend[0] = 1;
    drive();
    model_cycle();
    chk("t5_in_hold0", dbg_state, 1);
    r0_ack = 0;
    do_reset();
    set_knobs(0, 100, 0, 0);
    pend[1] = 1;
    drive(); #1;
    chk("t5_r1_gnt_after", r1_gnt, 1);
    model_cycle();

    // stray response with nothing outstanding is drained, not routed
    do_reset();
    set_knobs(0, 0, 0, 0);
    drive();
    dmem_recv  = 1'b1;
    dmem_rdata = 32'h5A5A_5A5A;
    #1;
    chk("stray_ack",  dmem_ack, 1);
    chk("stray_r0",   r0_recv, 0);
    chk("stray_r1",   r1_recv, 0);
    model_cycle();

    // random phases
    do_reset();
    set_knobs(40, 60, 50, 70);
    for (int k = 0; k < 4000; k++) begin
      drive();
      model_cycle();
    end
    set_knobs(90, 80, 30, 50);
    for (int k = 0; k < 3000; k++) begin
      drive();
      model_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
